// File: rtl/clk_ratio_meter_pkg.sv
// Shared types and constants for clk_ratio_meter.
//   state_e   : measurement FSM states (IDLE / ARM / MEASURE)
//   AVG_N     : number of periods averaged when CLK_RATIO_METER_AVG_EN is defined
//   AVG_SHIFT : log2(AVG_N), used for the truncating divide
package clk_ratio_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

  localparam int unsigned AVG_N     = 4;
  localparam int unsigned AVG_SHIFT = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser chain plus rising-edge detector for a possibly asynchronous input.
// Ports:
//   i_CLK     in  1  clock
//   i_RST     in  1  synchronous active-high reset
//   sig_i     in  1  raw input
//   sig_o     out 1  synchronised input (last sync stage)
//   rise_o_c  out 1  combinational one-cycle pulse on a synchronised 0->1 transition
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic sig_i,
  output logic sig_o,
  output logic rise_o_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d_q;

  // Shift chain; bit 0 is the metastability-exposed first stage.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      sync_q  <= '0;
      sig_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
      sig_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_o    = sync_q[SYNC_STAGES-1];
  assign rise_o_c = sync_q[SYNC_STAGES-1] & ~sig_d_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures the period and high time of a slow clock-like input in i_CLK cycles
// and flags an input that stops toggling.
// Optional feature macro: CLK_RATIO_METER_AVG_EN (report the truncated mean of
// every AVG_N consecutive periods instead of each period).
// Ports:
//   i_CLK    in  1      system clock
//   i_RST    in  1      synchronous active-high reset
//   i_EN     in  1      measurement enable (level)
//   i_SIG    in  1      signal under measurement, may be asynchronous
//   o_RATIO  out CNT_W  rise-to-rise period in i_CLK cycles
//   o_HIGH   out CNT_W  cycles the synchronised input was high in that period
//   o_VALID  out 1      one-cycle pulse when o_RATIO/o_HIGH update
//   o_STUCK  out 1      no rising edge within 2^CNT_W-1 cycles
module clk_ratio_meter
  import clk_ratio_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_EN,
  input  logic             i_SIG,
  output logic [CNT_W-1:0] o_RATIO,
  output logic [CNT_W-1:0] o_HIGH,
  output logic             o_VALID,
  output logic             o_STUCK
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s_sig;
  logic             rise_c;
  state_e           state_q;
  logic [CNT_W-1:0] p_cnt_q;
  logic [CNT_W-1:0] h_cnt_q;
  logic [CNT_W-1:0] ratio_q;
  logic [CNT_W-1:0] high_q;
  logic             valid_q;
  logic             stuck_q;

`ifdef CLK_RATIO_METER_AVG_EN
  localparam int unsigned SUM_W     = CNT_W + AVG_SHIFT;
  localparam int unsigned AVG_IDX_W = AVG_SHIFT;

  logic [SUM_W-1:0]     sum_p_q;
  logic [SUM_W-1:0]     sum_h_q;
  logic [SUM_W-1:0]     sum_p_d;
  logic [SUM_W-1:0]     sum_h_d;
  logic [AVG_IDX_W-1:0] avg_idx_q;

  // Running sums including the period that is closing this cycle.
  assign sum_p_d = sum_p_q + SUM_W'(p_cnt_q);
  assign sum_h_d = sum_h_q + SUM_W'(h_cnt_q);
`endif

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_CLK    (i_CLK),
    .i_RST    (i_RST),
    .sig_i    (i_SIG),
    .sig_o    (s_sig),
    .rise_o_c (rise_c)
  );

  // Measurement FSM, counters, optional averager and output registers.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= IDLE;
      p_cnt_q   <= '0;
      h_cnt_q   <= '0;
      ratio_q   <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      stuck_q   <= 1'b0;
`ifdef CLK_RATIO_METER_AVG_EN
      sum_p_q   <= '0;
      sum_h_q   <= '0;
      avg_idx_q <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (!i_EN) begin
        state_q   <= IDLE;
        p_cnt_q   <= '0;
        h_cnt_q   <= '0;
`ifdef CLK_RATIO_METER_AVG_EN
        sum_p_q   <= '0;
        sum_h_q   <= '0;
        avg_idx_q <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: state_q <= ARM;

          // First edge only opens a period; nothing to report yet.
          ARM: begin
            if (rise_c) begin
              state_q <= MEASURE;
              p_cnt_q <= CNT_W'(1);
              h_cnt_q <= CNT_W'(1);
            end
          end

          MEASURE: begin
            if (rise_c) begin
              // Rise wins over saturation: a period of exactly CNT_MAX is valid.
              p_cnt_q <= CNT_W'(1);
              h_cnt_q <= CNT_W'(1);
`ifdef CLK_RATIO_METER_AVG_EN
              if (avg_idx_q == AVG_IDX_W'(AVG_N - 1)) begin
                ratio_q   <= CNT_W'(sum_p_d >> AVG_SHIFT);
                high_q    <= CNT_W'(sum_h_d >> AVG_SHIFT);
                valid_q   <= 1'b1;
                stuck_q   <= 1'b0;
                sum_p_q   <= '0;
                sum_h_q   <= '0;
                avg_idx_q <= '0;
              end else begin
                sum_p_q   <= sum_p_d;
                sum_h_q   <= sum_h_d;
                avg_idx_q <= avg_idx_q + AVG_IDX_W'(1);
              end
`else
              ratio_q <= p_cnt_q;
              high_q  <= h_cnt_q;
              valid_q <= 1'b1;
              stuck_q <= 1'b0;
`endif
            end else if (p_cnt_q == CNT_MAX) begin
              state_q   <= ARM;
              p_cnt_q   <= '0;
              h_cnt_q   <= '0;
              ratio_q   <= '0;
              high_q    <= '0;
              stuck_q   <= 1'b1;
`ifdef CLK_RATIO_METER_AVG_EN
              sum_p_q   <= '0;
              sum_h_q   <= '0;
              avg_idx_q <= '0;
`endif
            end else begin
              p_cnt_q <= p_cnt_q + CNT_W'(1);
              if (s_sig) begin
                h_cnt_q <= h_cnt_q + CNT_W'(1);
              end
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_RATIO = ratio_q;
  assign o_HIGH  = high_q;
  assign o_VALID = valid_q;
  assign o_STUCK = stuck_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Self-checking bench for clk_ratio_meter (CNT_W=8, SYNC_STAGES=2).
module tb_clk_ratio_meter;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             sig;
  logic [CNT_W-1:0] ratio;
  logic [CNT_W-1:0] high;
  logic             valid;
  logic             stuck;

  clk_ratio_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .i_CLK   (clk),
    .i_RST   (rst),
    .i_EN    (en),
    .i_SIG   (sig),
    .o_RATIO (ratio),
    .o_HIGH  (high),
    .o_VALID (valid),
    .o_STUCK (stuck)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ratio;
    int high;
    int stuck;
  } rep_t;

  typedef struct {
    int p;
    int h;
    int exp_r;
    int exp_h;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  rep_t got_q[$];
  rep_t exp_q[$];
  rep_t mon_r;
  vec_t tbl[8];
  int   ps[$];
  int   hs[$];

  // Every o_VALID pulse is logged as a report.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      mon_r.ratio = int'(ratio);
      mon_r.high  = int'(high);
      mon_r.stuck = int'(stuck);
      got_q.push_back(mon_r);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_period(input int p, input int h);
    sig = 1'b1;
    cyc(h);
    sig = 1'b0;
    cyc(p - h);
  endtask

  // Restart measurement from scratch: drop enable, then re-arm with input low.
  task automatic preamble();
    en  = 1'b0;
    sig = 1'b0;
    cyc(3);
    en = 1'b1;
    cyc(4);
    got_q.delete();
  endtask

  task automatic run_periods(input int p_in[$], input int h_in[$]);
    preamble();
    foreach (p_in[i]) drive_period(p_in[i], h_in[i]);
    sig = 1'b1;
    cyc(1);
    sig = 1'b0;
    cyc(5);
  endtask

  // Reference: every measured period is reported, or the truncated mean of
  // each complete group of four when averaging is built in.
  task automatic model(input int p_in[$], input int h_in[$]);
    rep_t r;
    exp_q.delete();
    r.stuck = 0;
`ifdef CLK_RATIO_METER_AVG_EN
    for (int g = 0; g + 3 < p_in.size(); g += 4) begin
      r.ratio = (p_in[g] + p_in[g+1] + p_in[g+2] + p_in[g+3]) / 4;
      r.high  = (h_in[g] + h_in[g+1] + h_in[g+2] + h_in[g+3]) / 4;
      exp_q.push_back(r);
    end
`else
    foreach (p_in[i]) begin
      r.ratio = p_in[i];
      r.high  = h_in[i];
      exp_q.push_back(r);
    end
`endif
  endtask

  task automatic compare_reports(input string tag);
    check($sformatf("%s count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s[%0d] ratio", tag, i), got_q[i].ratio, exp_q[i].ratio);
      check($sformatf("%s[%0d] high", tag, i), got_q[i].high, exp_q[i].high);
      check($sformatf("%s[%0d] stuck", tag, i), got_q[i].stuck, 0);
    end
  endtask

  initial begin
    int lat;
    int n_before;
    int j;

    tbl[0] = '{4, 2, 4, 2};
    tbl[1] = '{10, 3, 10, 3};
    tbl[2] = '{2, 1, 2, 1};
    tbl[3] = '{3, 2, 3, 2};
    tbl[4] = '{255, 100, 255, 100};
    tbl[5] = '{7, 6, 7, 6};
    tbl[6] = '{5, 1, 5, 1};
    tbl[7] = '{16, 8, 16, 8};

    rst = 1'b1;
    en  = 1'b0;
    sig = 1'b0;
    cyc(3);
    check("reset ratio", int'(ratio), 0);
    check("reset high", int'(high), 0);
    check("reset valid", int'(valid), 0);
    check("reset stuck", int'(stuck), 0);
    rst = 1'b0;
    cyc(2);

    // Table of directed periods including the 2-cycle minimum and 255 maximum.
    ps.delete();
    hs.delete();
    foreach (tbl[i]) begin
      ps.push_back(tbl[i].p);
      hs.push_back(tbl[i].h);
    end
    run_periods(ps, hs);
`ifdef CLK_RATIO_METER_AVG_EN
    model(ps, hs);
    compare_reports("table");
`else
    check("table count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      check($sformatf("table[%0d] ratio", i), got_q[i].ratio, tbl[i].exp_r);
      check($sformatf("table[%0d] high", i), got_q[i].high, tbl[i].exp_h);
    end
`endif

    // Random synchronous waveform against the reference.
    ps.delete();
    hs.delete();
    for (int i = 0; i < 32; i++) begin
      int p;
      p = int'($urandom_range(2, 40));
      ps.push_back(p);
      hs.push_back(int'($urandom_range(1, p - 1)));
    end
    run_periods(ps, hs);
    model(ps, hs);
    compare_reports("random");

`ifdef CLK_RATIO_METER_AVG_EN
    ps = '{4, 4, 6, 6};
    hs = '{2, 2, 3, 3};
    run_periods(ps, hs);
    check("avg 4466 count", got_q.size(), 1);
    if (got_q.size() > 0) check("avg 4466 ratio", got_q[0].ratio, 5);
    ps = '{4, 4, 4, 5};
    hs = '{2, 2, 2, 2};
    run_periods(ps, hs);
    check("avg 4445 count", got_q.size(), 1);
    if (got_q.size() > 0) check("avg 4445 ratio", got_q[0].ratio, 4);
`else
    // Latency from input rise to o_VALID, and pulse width.
    preamble();
    drive_period(4, 2);
    drive_period(4, 2);
    sig = 1'b1;
    lat = -1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      if (k == 2) sig = 1'b0;
      if (lat < 0 && valid === 1'b1) begin
        lat = k;
        check("latency ratio", int'(ratio), 4);
        check("latency high", int'(high), 2);
      end
      if (k == 4) check("valid pulse width", int'(valid), 0);
    end
    check("latency cycles", lat, int'(SYNC) + 1);

    // Input stops after that rise: stuck exactly when the counter saturates.
    n_before = got_q.size();
    cyc(251);
    check("stuck before saturation", int'(stuck), 0);
    cyc(1);
    check("stuck at saturation", int'(stuck), 1);
    check("stuck ratio", int'(ratio), 0);
    check("stuck high", int'(high), 0);
    check("stuck no valid", got_q.size(), n_before);

    // Resume: first rise only re-arms, second rise reports and clears stuck.
    drive_period(4, 2);
    sig = 1'b1;
    cyc(2);
    sig = 1'b0;
    check("stuck held after 1st rise", int'(stuck), 1);
    cyc(1);
    check("resume valid", int'(valid), 1);
    check("resume ratio", int'(ratio), 4);
    check("resume high", int'(high), 2);
    check("resume stuck cleared", int'(stuck), 0);
    cyc(4);

    // Reset mid-period.
    preamble();
    drive_period(5, 2);
    drive_period(5, 2);
    sig = 1'b1;
    cyc(2);
    sig = 1'b0;
    cyc(2);
    check("pre-reset ratio", int'(ratio), 5);
    rst = 1'b1;
    cyc(1);
    check("post-reset ratio", int'(ratio), 0);
    check("post-reset high", int'(high), 0);
    check("post-reset valid", int'(valid), 0);
    check("post-reset stuck", int'(stuck), 0);
    rst = 1'b0;
    cyc(4);
    got_q.delete();
    drive_period(5, 2);
    check("reset 1st rise no valid", got_q.size(), 0);
    sig = 1'b1;
    cyc(2);
    sig = 1'b0;
    cyc(3);
    ps = '{5};
    hs = '{2};
    model(ps, hs);
    compare_reports("after reset");

    // Enable dropped mid-period: outputs hold, no reports while disabled.
    preamble();
    drive_period(6, 3);
    drive_period(6, 3);
    sig = 1'b1;
    cyc(2);
    sig = 1'b0;
    cyc(2);
    en = 1'b0;
    n_before = got_q.size();
    drive_period(6, 3);
    drive_period(6, 3);
    drive_period(6, 3);
    check("disabled no valid", got_q.size(), n_before);
    check("disabled ratio held", int'(ratio), 6);
    check("disabled high held", int'(high), 3);
    check("disabled stuck held", int'(stuck), 0);
    en = 1'b1;
    cyc(4);
    got_q.delete();
    drive_period(7, 2);
    sig = 1'b1;
    cyc(2);
    sig = 1'b0;
    cyc(3);
    ps = '{7};
    hs = '{2};
    model(ps, hs);
    compare_reports("re-enable");
`endif

    // Asynchronous input: period 100 time units (10 clocks) with jitter.
    preamble();
    #2;
    for (int i = 0; i < 12; i++) begin
      sig = 1'b1;
      #30;
      sig = 1'b0;
      j = 2 * int'($urandom_range(0, 4)) - 4;
      #(70 + j);
    end
    cyc(6);
`ifdef CLK_RATIO_METER_AVG_EN
    check("async count", got_q.size(), 2);
`else
    check("async count", got_q.size(), 11);
`endif
    foreach (got_q[i]) begin
      check_range($sformatf("async[%0d] ratio", i), got_q[i].ratio, 9, 11);
      check_range($sformatf("async[%0d] high", i), got_q[i].high, 2, 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
